avmm_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one Avalon-MM master port (the HPS SDRAM / lightweight bridge slave) between NUM_REQ fabric masters, e.g. a pixel reader and a compute engine.
- Sits between the requesters and the system interconnect.
- Serialises commands, supports pipelined reads with up to MAX_PEND outstanding, and routes readdatavalid back to the issuing requester through a tag FIFO.

---
 rtl/avmm_arb_pkg.sv | 33 +++
 rtl/avmm_rr_arbiter_if.sv | 50 +++++
 rtl/avmm_rr_arbiter_tag_fifo.sv | 79 +++++++
 rtl/avmm_rr_arbiter.sv | 145 ++++++++++++++
 tb/tb_avmm_rr_arbiter.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/avmm_arb_pkg.sv
// ============================================================================
// Module   : avmm_arb_pkg
// Brief    : Shared types, constants and helpers for the Avalon-MM RR arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package avmm_arb_pkg;

    localparam int MAX_TAG_W = 3;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    // A single requester still needs a one-bit tag.
    function automatic int tag_w(input int num_req);
        return (num_req <= 2) ? 1 : clog2(num_req);
    endfunction

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/avmm_rr_arbiter_if.sv
// ============================================================================
// Module   : avmm_rr_arbiter_if
// Brief    : Requester-side (s_*) and interconnect-side (m_*) Avalon-MM bundle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface avmm_rr_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
);
    localparam int BE_W = DATA_W / 8;

    logic [NUM_REQ*ADDR_W-1:0] s_address;
    logic [NUM_REQ-1:0]        s_read;
    logic [NUM_REQ-1:0]        s_write;
    logic [NUM_REQ*DATA_W-1:0] s_writedata;
    logic [NUM_REQ*BE_W-1:0]   s_byteenable;
    logic [NUM_REQ-1:0]        s_waitrequest;
    logic [DATA_W-1:0]         s_readdata;
    logic [NUM_REQ-1:0]        s_readdatavalid;

    logic [ADDR_W-1:0]         m_address;
    logic                      m_read;
    logic                      m_write;
    logic [DATA_W-1:0]         m_writedata;
    logic [BE_W-1:0]           m_byteenable;
    logic                      m_waitrequest;
    logic [DATA_W-1:0]         m_readdata;
    logic                      m_readdatavalid;

    // slave: the arbiter's view; master: the surrounding requesters and interconnect.
    modport slave (
        input  s_address, s_read, s_write, s_writedata, s_byteenable,
        output s_waitrequest, s_readdata, s_readdatavalid,
        output m_address, m_read, m_write, m_writedata, m_byteenable,
        input  m_waitrequest, m_readdata, m_readdatavalid
    );

    modport master (
        output s_address, s_read, s_write, s_writedata, s_byteenable,
        input  s_waitrequest, s_readdata, s_readdatavalid,
        input  m_address, m_read, m_write, m_writedata, m_byteenable,
        output m_waitrequest, m_readdata, m_readdatavalid
    );

endinterface

`default_nettype wire

// File: rtl/avmm_rr_arbiter_tag_fifo.sv
// ============================================================================
// Module   : tag_fifo
// Brief    : Synchronous FIFO holding the requester tag of each pending read.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tag_fifo
    import avmm_arb_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = 8
) (
    input  wire logic                     clk_i,
    input  wire logic                     rst_ni,
    input  wire logic                     push_i,
    input  wire logic [WIDTH-1:0]         data_i,
    input  wire logic                     pop_i,
    output logic      [WIDTH-1:0]         data_o,
    output logic                          full_o,
    output logic                          empty_o,
    output logic      [clog2(DEPTH):0]    count_o
);

    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == DEPTH_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    // A full FIFO may still accept a push when the same cycle frees a slot.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

`default_nettype wire

// File: rtl/avmm_rr_arbiter.sv
// ============================================================================
// Module   : avmm_rr_arbiter
// Brief    : Round-robin share of one Avalon-MM master among NUM_REQ requesters
//            with pipelined reads routed back through a tag FIFO.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module avmm_rr_arbiter
    import avmm_arb_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_PEND = 8
) (
    input  wire logic           clk_clk,
    input  wire logic           reset_reset_n,
    avmm_rr_arbiter_if.slave    bus,
    output logic                err_orphan
);

    localparam int TAG_W = tag_w(NUM_REQ);
    localparam int CNT_W = clog2(MAX_PEND) + 1;
    localparam int BE_W  = DATA_W / 8;
    localparam logic [CNT_W-1:0] PEND_MAX = CNT_W'(MAX_PEND);
    localparam logic [TAG_W-1:0] LAST_REQ = TAG_W'(NUM_REQ - 1);

    arb_state_t        state_q;
    logic [TAG_W-1:0]  grant_q;
    logic [TAG_W-1:0]  rr_ptr_q;
    logic              err_orphan_q;

    logic [NUM_REQ-1:0] eligible_w;
    logic               found_w;
    logic [TAG_W-1:0]   pick_w;
    int                 idx_w;

    logic               busy_w;
    logic               g_read_w;
    logic               g_write_w;
    logic               m_read_w;
    logic               m_write_w;
    logic               accept_w;
    logic               push_w;
    logic               pop_w;
    logic [TAG_W-1:0]   head_w;
    logic               fifo_full_w;
    logic               fifo_empty_w;
    logic [CNT_W-1:0]   pending_w;

    assign eligible_w = bus.s_write | (bus.s_read & {NUM_REQ{pending_w < PEND_MAX}});

    // Cyclic search starting at rr_ptr_q; first eligible requester wins.
    always_comb begin
        found_w = 1'b0;
        pick_w  = '0;
        idx_w   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx_w = int'(rr_ptr_q) + k;
            if (idx_w >= NUM_REQ) begin
                idx_w = idx_w - NUM_REQ;
            end
            if (!found_w && eligible_w[idx_w]) begin
                found_w = 1'b1;
                pick_w  = TAG_W'(idx_w);
            end
        end
    end

    assign busy_w    = (state_q == BUSY);
    assign g_read_w  = bus.s_read[grant_q];
    assign g_write_w = bus.s_write[grant_q];
    assign m_write_w = busy_w & g_write_w;
    assign m_read_w  = busy_w & g_read_w & ~g_write_w & ~fifo_full_w;
    assign accept_w  = (m_read_w | m_write_w) & ~bus.m_waitrequest;

    assign bus.m_read       = m_read_w;
    assign bus.m_write      = m_write_w;
    assign bus.m_address    = bus.s_address[int'(grant_q)*ADDR_W +: ADDR_W];
    assign bus.m_writedata  = bus.s_writedata[int'(grant_q)*DATA_W +: DATA_W];
    assign bus.m_byteenable = bus.s_byteenable[int'(grant_q)*BE_W +: BE_W];

    always_comb begin
        bus.s_waitrequest = '1;
        if (busy_w) begin
            bus.s_waitrequest[grant_q] = bus.m_waitrequest;
        end
    end

    assign push_w = accept_w & m_read_w;
    assign pop_w  = bus.m_readdatavalid & ~fifo_empty_w;

    assign bus.s_readdata      = bus.m_readdata;
    assign bus.s_readdatavalid = (NUM_REQ'(1) << head_w) & {NUM_REQ{pop_w}};
    assign err_orphan          = err_orphan_q;

    tag_fifo #(
        .WIDTH (TAG_W),
        .DEPTH (MAX_PEND)
    ) u_tag_fifo (
        .clk_i   (clk_clk),
        .rst_ni  (reset_reset_n),
        .push_i  (push_w),
        .data_i  (grant_q),
        .pop_i   (pop_w),
        .data_o  (head_w),
        .full_o  (fifo_full_w),
        .empty_o (fifo_empty_w),
        .count_o (pending_w)
    );

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            rr_ptr_q     <= '0;
            err_orphan_q <= 1'b0;
        end else begin
            if (bus.m_readdatavalid && fifo_empty_w) begin
                err_orphan_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (found_w) begin
                        grant_q <= pick_w;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (accept_w) begin
                        rr_ptr_q <= (grant_q == LAST_REQ) ? '0 : grant_q + TAG_W'(1);
                        state_q  <= IDLE;
                    end else if (!g_read_w && !g_write_w) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_avmm_rr_arbiter.sv
// ============================================================================
// Module   : tb_avmm_rr_arbiter
// Brief    : Directed self-checking bench for the Avalon-MM round-robin arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_avmm_rr_arbiter;

    logic clk_clk;
    logic reset_reset_n;
    logic err_orphan;

    int n_checks;
    int n_fail;

    avmm_rr_arbiter_if #(.NUM_REQ(2), .ADDR_W(32), .DATA_W(32)) bus ();

    avmm_rr_arbiter #(
        .NUM_REQ  (2),
        .ADDR_W   (32),
        .DATA_W   (32),
        .MAX_PEND (8)
    ) dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .bus           (bus),
        .err_orphan    (err_orphan)
    );

    initial clk_clk = 1'b0;
    always #5 clk_clk = ~clk_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_clk);
        #2;
    endtask

    task automatic clear_inputs();
        bus.s_address       = '0;
        bus.s_read          = '0;
        bus.s_write         = '0;
        bus.s_writedata     = '0;
        bus.s_byteenable    = '1;
        bus.m_waitrequest   = 1'b0;
        bus.m_readdata      = '0;
        bus.m_readdatavalid = 1'b0;
    endtask

    task automatic do_reset();
        reset_reset_n = 1'b0;
        clear_inputs();
        step();
        step();
        reset_reset_n = 1'b1;
        #1;
    endtask

    int accepts;
    int acc0;
    int acc1;
    int back2back;
    logic prev_cmd;
    logic cmd;
    logic [63:0] g;

    initial begin
        n_checks = 0;
        n_fail   = 0;

        // Reset values, sampled while reset is held
        reset_reset_n = 1'b0;
        clear_inputs();
        #12;
        check("rst_m_read", bus.m_read, 1'b0);
        check("rst_m_write", bus.m_write, 1'b0);
        check("rst_s_waitreq", bus.s_waitrequest, 2'b11);
        check("rst_s_rdv", bus.s_readdatavalid, 2'b00);
        check("rst_err", err_orphan, 1'b0);
        check("rst_pending", dut.pending_w, 0);

        // Single read from req0, returned three cycles after acceptance
        do_reset();
        step();
        bus.s_read[0]        = 1'b1;
        bus.s_address[31:0]  = 32'h100;
        #1;
        check("rd1_idle_mread", bus.m_read, 1'b0);
        check("rd1_idle_waitreq", bus.s_waitrequest, 2'b11);
        step();
        check("rd1_mread", bus.m_read, 1'b1);
        check("rd1_maddr", bus.m_address, 32'h100);
        check("rd1_waitreq", bus.s_waitrequest, 2'b10);
        step();
        bus.s_read[0] = 1'b0;
        #1;
        check("rd1_mread_once", bus.m_read, 1'b0);
        check("rd1_pending1", dut.pending_w, 1);
        step();
        step();
        bus.m_readdatavalid = 1'b1;
        bus.m_readdata      = 32'hDEADBEEF;
        #1;
        check("rd1_rdv", bus.s_readdatavalid, 2'b01);
        check("rd1_rdata", bus.s_readdata, 32'hDEADBEEF);
        step();
        bus.m_readdatavalid = 1'b0;
        #1;
        check("rd1_rdv_off", bus.s_readdatavalid, 2'b00);
        check("rd1_pending0", dut.pending_w, 0);
        check("rd1_no_orphan", err_orphan, 1'b0);

        // Fairness: both requesters hold writes continuously
        do_reset();
        step();
        bus.s_write       = 2'b11;
        bus.s_writedata   = {32'h2222_0001, 32'h1111_0000};
        bus.s_address     = {32'h0000_0200, 32'h0000_0100};
        #1;
        accepts   = 0;
        acc0      = 0;
        acc1      = 0;
        back2back = 0;
        prev_cmd  = 1'b0;
        for (int c = 0; c < 16; c++) begin
            cmd = bus.m_write & ~bus.m_waitrequest;
            if (cmd && prev_cmd) back2back++;
            if (cmd) begin
                g = (bus.s_waitrequest == 2'b10) ? 64'd0 : 64'd1;
                check("fair_grant", g, accepts % 2);
                check("fair_wdata", bus.m_writedata,
                      (accepts % 2 == 0) ? 32'h1111_0000 : 32'h2222_0001);
                if (g == 0) acc0++; else acc1++;
                accepts++;
            end
            prev_cmd = cmd;
            step();
        end
        bus.s_write = 2'b00;
        check("fair_total", accepts, 8);
        check("fair_req0", acc0, 4);
        check("fair_req1", acc1, 4);
        check("fair_no_b2b", back2back, 0);

        // Slave stalls for five cycles during req1's write
        do_reset();
        step();
        bus.m_waitrequest      = 1'b1;
        bus.s_write[1]         = 1'b1;
        bus.s_address[63:32]   = 32'h200;
        bus.s_writedata[63:32] = 32'hA5A5A5A5;
        #1;
        for (int c = 0; c < 5; c++) begin
            step();
            check("stall_mwrite", bus.m_write, 1'b1);
            check("stall_maddr", bus.m_address, 32'h200);
            check("stall_wdata", bus.m_writedata, 32'hA5A5A5A5);
            check("stall_waitreq", bus.s_waitrequest, 2'b11);
        end
        step();
        bus.m_waitrequest = 1'b0;
        #1;
        check("stall_release", bus.s_waitrequest, 2'b01);
        step();
        check("stall_accepted", bus.m_write, 1'b0);
        bus.s_write = 2'b00;

        // Outstanding limit: eight reads with no returns
        do_reset();
        step();
        bus.s_read[0]       = 1'b1;
        bus.s_address[31:0] = 32'h400;
        #1;
        accepts = 0;
        for (int c = 0; c < 16; c++) begin
            if (bus.m_read && !bus.m_waitrequest) accepts++;
            step();
        end
        check("lim_reads", accepts, 8);
        check("lim_pending8", dut.pending_w, 8);
        step();
        check("lim_9th_blocked", bus.m_read, 1'b0);
        step();
        check("lim_9th_blocked2", bus.m_read, 1'b0);
        bus.s_write[1] = 1'b1;
        #1;
        step();
        check("lim_wr_mwrite", bus.m_write, 1'b1);
        check("lim_wr_mread", bus.m_read, 1'b0);
        check("lim_wr_waitreq", bus.s_waitrequest, 2'b01);
        step();
        bus.s_write[1] = 1'b0;
        #1;
        check("lim_pending_wr", dut.pending_w, 8);
        bus.m_readdatavalid = 1'b1;
        bus.m_readdata      = 32'h0000_0001;
        #1;
        check("lim_ret_rdv", bus.s_readdatavalid, 2'b01);
        step();
        bus.m_readdatavalid = 1'b0;
        #1;
        check("lim_pending7", dut.pending_w, 7);
        check("lim_idle_mread", bus.m_read, 1'b0);
        step();
        check("lim_9th_issued", bus.m_read, 1'b1);
        step();
        check("lim_pending_back8", dut.pending_w, 8);
        bus.s_read = 2'b00;

        // Read return routing across requesters, with overlapping push and pop
        do_reset();
        step();
        bus.s_read = 2'b01;
        #1;
        step();
        check("ord_rd0", bus.m_read, 1'b1);
        step();
        bus.s_read = 2'b10;
        #1;
        step();
        check("ord_rd1_grant", bus.s_waitrequest, 2'b01);
        step();
        bus.s_read          = 2'b01;
        bus.m_readdatavalid = 1'b1;
        bus.m_readdata      = 32'hAAAA_0000;
        #1;
        check("ord_pending2", dut.pending_w, 2);
        check("ord_ret1", bus.s_readdatavalid, 2'b01);
        step();
        bus.m_readdata = 32'hBBBB_1111;
        #1;
        check("ord_push_pop_rd", bus.m_read, 1'b1);
        check("ord_ret2", bus.s_readdatavalid, 2'b10);
        check("ord_pending_mid", dut.pending_w, 1);
        step();
        bus.s_read     = 2'b00;
        bus.m_readdata = 32'hCCCC_2222;
        #1;
        check("ord_pending_kept", dut.pending_w, 1);
        check("ord_ret3", bus.s_readdatavalid, 2'b01);
        check("ord_ret3_data", bus.s_readdata, 32'hCCCC_2222);
        step();
        bus.m_readdatavalid = 1'b0;
        #1;
        check("ord_pending0", dut.pending_w, 0);

        // Orphan return, then reset while busy with three reads pending
        do_reset();
        step();
        bus.m_readdatavalid = 1'b1;
        #1;
        check("orph_no_rdv", bus.s_readdatavalid, 2'b00);
        step();
        bus.m_readdatavalid = 1'b0;
        #1;
        check("orph_err", err_orphan, 1'b1);
        check("orph_pending", dut.pending_w, 0);
        bus.s_read = 2'b01;
        #1;
        for (int c = 0; c < 7; c++) step();
        check("rst_mid_mread", bus.m_read, 1'b1);
        check("rst_mid_pending3", dut.pending_w, 3);
        check("rst_mid_err_sticky", err_orphan, 1'b1);
        reset_reset_n = 1'b0;
        #1;
        check("rst_async_mread", bus.m_read, 1'b0);
        step();
        check("rst_next_mread", bus.m_read, 1'b0);
        check("rst_next_pending", dut.pending_w, 0);
        check("rst_next_err", err_orphan, 1'b0);
        check("rst_next_waitreq", bus.s_waitrequest, 2'b11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
